// File: rtl/coef_reload_pkg.sv
// Shared types and defaults for the FIR coefficient reload sequencer.
// The FLUSH state exists only when COEF_RELOAD_FLUSH_EN is defined.
package coef_reload_pkg;

  localparam int TAPS_DEF   = 16;
  localparam int COEF_W_DEF = 16;
  localparam int IDX_W_DEF  = 2;
  localparam int DEC_W_DEF  = 3;
  localparam int TAP_W_DEF  = $clog2(TAPS_DEF);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    HOLD,
    LOAD,
    COMMIT,
`ifdef COEF_RELOAD_FLUSH_EN
    FLUSH,
`endif
    DONE
  } state_t;

  typedef struct packed {
    logic filt_en;
    logic out_gate;
    logic busy;
    logic done;
  } ctrl_t;

  // Datapath control levels that hold for the whole time a state is occupied.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: begin
        c.filt_en  = 1'b1;
        c.out_gate = 1'b1;
      end
      HOLD, LOAD, COMMIT: c.busy = 1'b1;
`ifdef COEF_RELOAD_FLUSH_EN
      FLUSH: begin
        c.filt_en = 1'b1;
        c.busy    = 1'b1;
      end
`endif
      DONE: begin
        c.filt_en  = 1'b1;
        c.out_gate = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/coef_flush_cnt.sv
// Down-counter of smp_valid strobes used to discard stale filter output
// after a coefficient reload; expire flags the strobe that ends the flush.
module coef_flush_cnt #(
  parameter int FLUSH_CNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic smp_valid,
  output logic expire
);

  localparam int CW = $clog2(FLUSH_CNT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(FLUSH_CNT);
    end else if (smp_valid && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = smp_valid && (cnt == CW'(1));

endmodule

// File: rtl/coef_reload_seq.sv
// Freezes the decimating FIR, streams a coefficient set from ROM and commits
// the new decimation rate; optional flush phase under COEF_RELOAD_FLUSH_EN.
module coef_reload_seq
  import coef_reload_pkg::*;
#(
  parameter int TAPS     = TAPS_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int DEC_W    = DEC_W_DEF,
  parameter int BOOT_IDX = 1
`ifdef COEF_RELOAD_FLUSH_EN
  ,
  parameter int FLUSH_CNT = TAPS
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req,
  input  logic [IDX_W-1:0]                req_idx,
  input  logic [DEC_W-1:0]                req_dec,
  input  logic                            smp_valid,
  output logic                            rom_rd,
  output logic [IDX_W+$clog2(TAPS)-1:0]   rom_addr,
  input  logic [COEF_W-1:0]               rom_data,
  output logic                            coef_we,
  output logic [$clog2(TAPS)-1:0]         coef_addr,
  output logic [COEF_W-1:0]               coef_data,
  output logic                            filt_en,
  output logic                            out_gate,
  output logic [DEC_W-1:0]                dec_rate,
  output logic [IDX_W-1:0]                active_idx,
  output logic                            busy,
  output logic                            done,
  output state_t                          state_dbg
);

  localparam int TAP_W = $clog2(TAPS);
  localparam logic [TAP_W:0] LAST_K = TAPS[TAP_W:0];
  localparam logic [TAP_W:0] K_ONE  = 1;

  state_t           state;
  ctrl_t            ctrl;
  logic [TAP_W:0]   k;
  logic [TAP_W:0]   k_nx;
  logic [IDX_W-1:0] tgt_idx;
  logic [DEC_W-1:0] tgt_dec;
  logic             pend_v;
  logic [IDX_W-1:0] pend_idx;
  logic [DEC_W-1:0] pend_dec;

  assign k_nx = k + K_ONE;

`ifdef COEF_RELOAD_FLUSH_EN
  logic flush_exp;

  coef_flush_cnt #(.FLUSH_CNT(FLUSH_CNT)) u_flush (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == COMMIT),
    .smp_valid (smp_valid),
    .expire    (flush_exp)
  );
`else
  logic unused_smp;
  assign unused_smp = smp_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      ctrl       <= '0;
      k          <= '0;
      rom_rd     <= 1'b0;
      rom_addr   <= '0;
      coef_we    <= 1'b0;
      coef_addr  <= '0;
      tgt_idx    <= '0;
      tgt_dec    <= '0;
      pend_v     <= 1'b0;
      pend_idx   <= '0;
      pend_dec   <= '0;
      dec_rate   <= '0;
      active_idx <= '0;
    end else begin
      // Requests that arrive while a load is in flight (including DONE) wait here; latest wins.
      if (req && (state != IDLE)) begin
        pend_v   <= 1'b1;
        pend_idx <= req_idx;
        pend_dec <= req_dec;
      end
      case (state)
        BOOT: begin
          tgt_idx <= IDX_W'(BOOT_IDX);
          tgt_dec <= '0;
          state   <= HOLD;
          ctrl    <= state_ctrl(HOLD);
        end
        IDLE: begin
          if (req) begin
            tgt_idx <= req_idx;
            tgt_dec <= req_dec;
            pend_v  <= 1'b0;
            state   <= HOLD;
            ctrl    <= state_ctrl(HOLD);
          end else if (pend_v) begin
            tgt_idx <= pend_idx;
            tgt_dec <= pend_dec;
            pend_v  <= 1'b0;
            state   <= HOLD;
            ctrl    <= state_ctrl(HOLD);
          end
        end
        HOLD: begin
          k        <= '0;
          rom_rd   <= 1'b1;
          rom_addr <= {tgt_idx, {TAP_W{1'b0}}};
          state    <= LOAD;
          ctrl     <= state_ctrl(LOAD);
        end
        LOAD: begin
          // ROM answers one cycle after the read, so writes trail reads by one tap.
          k <= k_nx;
          if (k == LAST_K) begin
            coef_we <= 1'b0;
            state   <= COMMIT;
            ctrl    <= state_ctrl(COMMIT);
          end else begin
            coef_we   <= 1'b1;
            coef_addr <= k[TAP_W-1:0];
            rom_rd    <= (k_nx != LAST_K);
            rom_addr  <= {tgt_idx, k_nx[TAP_W-1:0]};
          end
        end
        COMMIT: begin
          dec_rate   <= tgt_dec;
          active_idx <= tgt_idx;
`ifdef COEF_RELOAD_FLUSH_EN
          state      <= FLUSH;
          ctrl       <= state_ctrl(FLUSH);
`else
          state      <= DONE;
          ctrl       <= state_ctrl(DONE);
`endif
        end
`ifdef COEF_RELOAD_FLUSH_EN
        FLUSH: begin
          if (flush_exp) begin
            state <= DONE;
            ctrl  <= state_ctrl(DONE);
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          ctrl  <= state_ctrl(IDLE);
        end
        default: begin
          state <= IDLE;
          ctrl  <= state_ctrl(IDLE);
        end
      endcase
    end
  end

  assign coef_data = coef_we ? rom_data : '0;
  assign filt_en   = ctrl.filt_en;
  assign out_gate  = ctrl.out_gate;
  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign state_dbg = state;

endmodule

// File: tb/tb_coef_reload_seq.sv
// Self-checking bench for coef_reload_seq: per-cycle behavioural model plus
// directed literal checks; follows COEF_RELOAD_FLUSH_EN like the design.
module tb_coef_reload_seq;
  import coef_reload_pkg::*;

  localparam int TAPS     = 16;
  localparam int COEF_W   = 16;
  localparam int IDX_W    = 2;
  localparam int DEC_W    = 3;
  localparam int BOOT_IDX = 1;
  localparam int TAP_W    = 4;
  localparam int AW       = IDX_W + TAP_W;
`ifdef COEF_RELOAD_FLUSH_EN
  localparam int FLUSH_CNT = TAPS;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic [IDX_W-1:0]  req_idx = '0;
  logic [DEC_W-1:0]  req_dec = '0;
  logic              smp_valid = 1'b0;
  logic              rom_rd;
  logic [AW-1:0]     rom_addr;
  logic [COEF_W-1:0] rom_data = '0;
  logic              coef_we;
  logic [TAP_W-1:0]  coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              filt_en, out_gate, busy, done;
  logic [DEC_W-1:0]  dec_rate;
  logic [IDX_W-1:0]  active_idx;
  state_t            dbg_state;

  always #5 clk = ~clk;

  coef_reload_seq #(
    .TAPS(TAPS), .COEF_W(COEF_W), .IDX_W(IDX_W), .DEC_W(DEC_W), .BOOT_IDX(BOOT_IDX)
`ifdef COEF_RELOAD_FLUSH_EN
    , .FLUSH_CNT(FLUSH_CNT)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .req_dec(req_dec),
    .smp_valid(smp_valid), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .filt_en(filt_en), .out_gate(out_gate), .dec_rate(dec_rate),
    .active_idx(active_idx), .busy(busy), .done(done), .state_dbg(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dec_hist[int];
  int done_q[$];
  int done_dec_q[$];
  int done_idx_q[$];
  logic [COEF_W-1:0] exp_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_q[$];
  int strobe_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- ROM and sample-strobe sources ----------------
  bit            s_rd;
  logic [AW-1:0] s_addr;
  int            smp_mode = 2;
  int            smp_ph = 0;

  // ROM word equals its address; garbage whenever no read was issued.
  always @(posedge clk) begin
    #1;
    rom_data = s_rd ? COEF_W'(s_addr) : COEF_W'($urandom);
  end

  always @(posedge clk) begin
    #1;
    smp_ph = (smp_ph == 2) ? 0 : smp_ph + 1;
    case (smp_mode)
      0:       smp_valid = 1'b0;
      1:       smp_valid = (smp_ph == 0);
      default: smp_valid = ($urandom_range(0, 2) == 0);
    endcase
  end

  // ---------------- behavioural model + compare ----------------
  bit m_boot = 1'b1;
  bit m_act = 1'b0;
  bit m_pv = 1'b0;
  int m_start, m_done_t, m_fc;
  int m_idx, m_dec, m_pidx, m_pdec;
  int m_cidx = 0;
  int m_cdec = 0;

  task automatic m_begin(input int idx, input int dec);
    m_act   = 1'b1;
    m_start = cyc + 1;
    m_idx   = idx;
    m_dec   = dec;
    m_fc    = 0;
`ifdef COEF_RELOAD_FLUSH_EN
    m_done_t = 1 << 30;
`else
    m_done_t = TAPS + 3;
`endif
  endtask

  always @(negedge clk) begin : mon
    int t;
    bit e_rd, e_we, e_filt, e_gate, e_busy, e_done;
    int e_raddr, e_caddr, e_cdata;
    cyc++;
    dec_hist[cyc] = int'(dec_rate);
    s_rd   = rom_rd;
    s_addr = rom_addr;
    if (!rst_n) begin
      chk("rst_rom_rd", rom_rd, 0);
      chk("rst_coef_we", coef_we, 0);
      chk("rst_coef_addr", coef_addr, 0);
      chk("rst_coef_data", coef_data, 0);
      chk("rst_filt_en", filt_en, 0);
      chk("rst_out_gate", out_gate, 0);
      chk("rst_dec_rate", dec_rate, 0);
      chk("rst_active_idx", active_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      m_boot = 1'b1; m_act = 1'b0; m_pv = 1'b0; m_cidx = 0; m_cdec = 0;
    end else begin
      if (done) begin
        done_q.push_back(cyc);
        done_dec_q.push_back(int'(dec_rate));
        done_idx_q.push_back(int'(active_idx));
      end
      if (coef_we) begin
        wr_addr_q.push_back(int'(coef_addr));
        wr_data_q.push_back(int'(coef_data));
      end
      if (rom_rd) rd_q.push_back(int'(rom_addr));
      if (smp_valid && filt_en && !out_gate) strobe_q.push_back(cyc);

      t = 0; e_rd = 0; e_we = 0; e_filt = 0; e_gate = 0; e_busy = 0; e_done = 0;
      e_raddr = 0; e_caddr = 0; e_cdata = 0;
      if (m_boot) begin
        e_filt = 0;
      end else if (!m_act) begin
        e_filt = 1; e_gate = 1;
      end else begin
        t = cyc - m_start;
        e_busy = 1;
        if (t >= 1 && t <= TAPS) begin
          e_rd = 1; e_raddr = m_idx * TAPS + t - 1;
        end
        if (t >= 2 && t <= TAPS + 1) begin
          e_we = 1; e_caddr = t - 2; e_cdata = m_idx * TAPS + t - 2;
          exp_q.push_back(COEF_W'(e_cdata));
        end
        if (t == m_done_t) begin
          e_done = 1; e_busy = 0; e_filt = 1; e_gate = 1;
        end else if (t > TAPS + 2) begin
          e_filt = 1;
        end
      end

      chk("rom_rd", rom_rd, e_rd);
      if (e_rd) chk("rom_addr", rom_addr, e_raddr);
      chk("coef_we", coef_we, e_we);
      if (e_we) begin
        chk("coef_addr", coef_addr, e_caddr);
        chk("coef_data", coef_data, exp_q.pop_front());
      end
      chk("filt_en", filt_en, e_filt);
      chk("out_gate", out_gate, e_gate);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("dec_rate", dec_rate, m_cdec);
      chk("active_idx", active_idx, m_cidx);

      if (m_boot) begin
        if (req) begin m_pv = 1; m_pidx = int'(req_idx); m_pdec = int'(req_dec); end
        m_begin(BOOT_IDX, 0);
        m_boot = 0;
      end else if (!m_act) begin
        if (req) begin
          m_begin(int'(req_idx), int'(req_dec)); m_pv = 0;
        end else if (m_pv) begin
          m_begin(m_pidx, m_pdec); m_pv = 0;
        end
      end else begin
        if (t == TAPS + 2) begin m_cidx = m_idx; m_cdec = m_dec; end
        if (t == m_done_t) m_act = 0;
`ifdef COEF_RELOAD_FLUSH_EN
        else if (t > TAPS + 2 && smp_valid) begin
          m_fc++;
          if (m_fc == FLUSH_CNT) m_done_t = t + 1;
        end
`endif
        if (req) begin m_pv = 1; m_pidx = int'(req_idx); m_pdec = int'(req_dec); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input int idx, input int dec, output int rcyc);
    @(posedge clk); #1;
    rcyc = cyc + 1;
    req = 1'b1; req_idx = idx[IDX_W-1:0]; req_dec = dec[DEC_W-1:0];
    @(posedge clk); #1;
    req = 1'b0; req_idx = IDX_W'($urandom); req_dec = DEC_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int n0;
    int i;
    n0 = done_q.size();
    i = 0;
    while (done_q.size() == n0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    n_cmp++;
    if (done_q.size() == n0) begin
      n_bad++;
      $display("FAIL done_timeout got=none exp=done within %0d cycles", budget);
      dcyc = -1;
    end else begin
      dcyc = done_q[$];
    end
  endtask

  task automatic chk_boot_load(input string tag);
    chk({tag, "_wr_cnt"}, wr_data_q.size(), TAPS);
    for (int k = 0; k < TAPS; k++) begin
      chk({tag, "_wr_addr"}, wr_addr_q[k], k);
      chk({tag, "_wr_data"}, wr_data_q[k], 16 + k);
    end
    chk({tag, "_idx"}, done_idx_q[$], 1);
    chk({tag, "_dec"}, done_dec_q[$], 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1, d, d1, d2, nd;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Boot load of set 1
    wait_done(400, d);
    chk_boot_load("boot");

    // Idle request idx 2 / dec 3
    repeat (3) @(posedge clk);
    rd_q.delete();
    do_req(2, 3, c0);
    wait_done(400, d);
    chk("idle_rd_cnt", rd_q.size(), 16);
    chk("idle_rd_first", rd_q[0], 32);
    chk("idle_rd_last", rd_q[15], 47);
    chk("idle_dec_before", dec_hist[c0 + 19], 0);
    chk("idle_dec_after", dec_hist[c0 + 20], 3);
`ifndef COEF_RELOAD_FLUSH_EN
    chk("idle_done_lat", d - c0, 20);
`endif

    // Two requests during a load: only the latest runs next
    repeat (3) @(posedge clk);
    do_req(1, 5, c1);
    repeat (4) @(posedge clk);
    do_req(3, 6, c1);
    repeat (2) @(posedge clk);
    do_req(0, 4, c1);
    wait_done(400, d1);
    rd_q.delete();
    wait_done(400, d2);
    chk("pend_rd_cnt", rd_q.size(), 16);
    chk("pend_rd_first", rd_q[0], 0);
    chk("pend_rd_last", rd_q[15], 15);
    chk("pend_dec", done_dec_q[$], 4);
    chk("pend_idx", done_idx_q[$], 0);
`ifndef COEF_RELOAD_FLUSH_EN
    chk("pend_start_gap", d2 - d1, 21);
`endif

    // Reset during LOAD tap 7, then a clean boot load
    repeat (3) @(posedge clk);
    do_req(2, 5, c1);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("abort_rom_rd", rom_rd, 0);
    chk("abort_busy", busy, 0);
    wr_addr_q.delete(); wr_data_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_done(400, d);
    chk_boot_load("reboot");

`ifdef COEF_RELOAD_FLUSH_EN
    // No strobes: stays in flush forever; then every third cycle
    repeat (3) @(posedge clk);
    smp_mode = 0;
    nd = done_q.size();
    do_req(3, 2, c1);
    repeat (60) @(negedge clk);
    #1;
    chk("stall_busy", busy, 1);
    chk("stall_gate", out_gate, 0);
    chk("stall_no_done", done_q.size(), nd);
    strobe_q.delete();
    smp_mode = 1;
    wait_done(400, d);
    chk("flush_strobes", strobe_q.size(), 16);
    chk("flush_done_after", d - strobe_q[15], 1);
`endif

    // Random traffic
    smp_mode = 2;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req     = ($urandom_range(0, 11) == 0);
      req_idx = IDX_W'($urandom);
      req_dec = DEC_W'($urandom);
    end
    @(posedge clk); #1;
    req = 1'b0;
    begin
      int n;
      n = 0;
      while ((m_act || m_pv || m_boot) && n < 3000) begin
        @(negedge clk); #1;
        n++;
      end
      chk("drain_idle", {m_act, m_pv, m_boot}, 0);
    end
    repeat (4) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
